// File: rtl/cvt_int_fp_mod.sv
`default_nettype none
// ============================================================================
// Module   : cvt_int_fp_mod
// Purpose  : Three-stage integer-to-floating-point converter (SNG/DBL/EXT),
//            result in the 84-bit FPU register format. Optional extended
//            format enabled by defining CVT_INT_FP_EXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cvt_int_fp_mod (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        en,
    input  logic [63:0] A,
    input  logic        isSigned,
    input  logic        is32b,
    input  logic        isSNG,
    input  logic        isDBL,
    input  logic        isEXT,
    input  logic [1:0]  rm,
    output logic [83:0] res,
    output logic        res_en,
    output logic        inexact
);

    localparam logic [1:0] c_FMT_SNG = 2'd0;
    localparam logic [1:0] c_FMT_DBL = 2'd1;
`ifdef CVT_INT_FP_EXT_EN
    localparam logic [1:0] c_FMT_EXT = 2'd2;
    localparam int         c_MW      = 64;
`else
    localparam int         c_MW      = 53;
`endif

    // ---------------- S1: capture, extend, magnitude ----------------
    logic [63:0] w_ext;
    logic [63:0] w_mag;
    logic        w_sign;
    logic [1:0]  w_fmt;

    always_comb begin
        if (is32b)
            w_ext = {{32{isSigned & A[31]}}, A[31:0]};
        else
            w_ext = A;
        w_sign = isSigned & w_ext[63];
        w_mag  = w_sign ? (~w_ext + 64'd1) : w_ext;
`ifdef CVT_INT_FP_EXT_EN
        if (isEXT)
            w_fmt = c_FMT_EXT;
        else if (isDBL)
            w_fmt = c_FMT_DBL;
        else
            w_fmt = c_FMT_SNG;
`else
        w_fmt = (isEXT | isDBL) ? c_FMT_DBL : c_FMT_SNG;
`endif
    end

    logic        r_v1;
    logic        r_sign1;
    logic [63:0] r_mag1;
    logic [1:0]  r_fmt1;
    logic [1:0]  r_rm1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
            r_fmt1  <= c_FMT_SNG;
            r_rm1   <= 2'd0;
        end else if (clkEn) begin
            r_v1    <= en;
            r_sign1 <= w_sign;
            r_mag1  <= w_mag;
            r_fmt1  <= w_fmt;
            r_rm1   <= rm;
        end
    end

    // ---------------- S2: normalize ----------------
    logic [6:0]  w_lz;
    logic [63:0] w_norm;

    always_comb begin
        w_lz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (r_mag1[i])
                w_lz = 7'(63 - i);
        end
        w_norm = r_mag1 << w_lz;
    end

    logic        r_v2;
    logic        r_sign2;
    logic [63:0] r_norm2;
    logic [6:0]  r_exp2;
    logic        r_zero2;
    logic [1:0]  r_fmt2;
    logic [1:0]  r_rm2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_norm2 <= '0;
            r_exp2  <= '0;
            r_zero2 <= 1'b0;
            r_fmt2  <= c_FMT_SNG;
            r_rm2   <= 2'd0;
        end else if (clkEn) begin
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_norm2 <= w_norm;
            r_exp2  <= 7'd63 - w_lz;
            r_zero2 <= (r_mag1 == 64'd0);
            r_fmt2  <= r_fmt1;
            r_rm2   <= r_rm1;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic [c_MW-1:0] w_kept;
    logic [c_MW:0]   w_sum;
    logic            w_guard;
    logic            w_sticky;
    logic            w_inc;
    logic            w_carry;
    logic [6:0]      w_e;
    logic [83:0]     w_res;
    logic            w_inexact;

    always_comb begin
        w_kept   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        case (r_fmt2)
            c_FMT_DBL: begin
                w_kept[52:0] = r_norm2[63:11];
                w_guard      = r_norm2[10];
                w_sticky     = |r_norm2[9:0];
            end
`ifdef CVT_INT_FP_EXT_EN
            c_FMT_EXT: begin
                w_kept[63:0] = r_norm2;
            end
`endif
            default: begin
                w_kept[23:0] = r_norm2[63:40];
                w_guard      = r_norm2[39];
                w_sticky     = |r_norm2[38:0];
            end
        endcase

        case (r_rm2)
            2'd0:    w_inc = w_guard & (w_sticky | w_kept[0]);
            2'd1:    w_inc = 1'b0;
            2'd2:    w_inc = r_sign2 & (w_guard | w_sticky);
            default: w_inc = ~r_sign2 & (w_guard | w_sticky);
        endcase

        w_sum     = {1'b0, w_kept} + {{c_MW{1'b0}}, w_inc};
        w_carry   = 1'b0;
        w_e       = r_exp2;
        w_res     = '0;
        // A carry-out leaves all fraction bits zero, i.e. mantissa 1.0
        case (r_fmt2)
            c_FMT_DBL: begin
                w_carry      = w_sum[53];
                w_e          = r_exp2 + {6'd0, w_carry};
                w_res[63:0]  = {r_sign2, ({4'd0, w_e} + 11'd1023), w_sum[51:0]};
            end
`ifdef CVT_INT_FP_EXT_EN
            c_FMT_EXT: begin
                w_carry      = w_sum[64];
                w_e          = r_exp2 + {6'd0, w_carry};
                w_res[83]    = r_sign2;
                w_res[82:68] = {8'd0, w_e} + 15'd16383;
                w_res[63:0]  = w_carry ? 64'h8000_0000_0000_0000 : w_sum[63:0];
            end
`endif
            default: begin
                w_carry      = w_sum[24];
                w_e          = r_exp2 + {6'd0, w_carry};
                w_res[31:0]  = {r_sign2, ({1'b0, w_e} + 8'd127), w_sum[22:0]};
            end
        endcase

        w_inexact = (w_guard | w_sticky) & ~r_zero2;
        if (r_zero2)
            w_res = '0;
    end

    // Hidden bits of SNG/DBL and the SNG select line carry no information
    logic w_unused;
    assign w_unused = ^{isSNG, w_sum[52], w_sum[23]};

    logic        r_v3;
    logic [83:0] r_res;
    logic        r_inexact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3      <= 1'b0;
            r_res     <= '0;
            r_inexact <= 1'b0;
        end else if (clkEn) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_res     <= w_res;
                r_inexact <= w_inexact;
            end
        end
    end

    assign res     = r_res;
    assign res_en  = r_v3;
    assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_cvt_int_fp_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvt_int_fp_mod
// Purpose  : Scoreboard bench for cvt_int_fp_mod with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvt_int_fp_mod;

    logic        clk = 1'b0;
    logic        rst, clkEn, en, isSigned, is32b, isSNG, isDBL, isEXT;
    logic [63:0] A;
    logic [1:0]  rm;
    logic [83:0] res;
    logic        res_en, inexact;

    always #5 clk = ~clk;

    cvt_int_fp_mod dut (
        .clk      (clk),
        .rst      (rst),
        .clkEn    (clkEn),
        .en       (en),
        .A        (A),
        .isSigned (isSigned),
        .is32b    (is32b),
        .isSNG    (isSNG),
        .isDBL    (isDBL),
        .isEXT    (isEXT),
        .rm       (rm),
        .res      (res),
        .res_en   (res_en),
        .inexact  (inexact)
    );

    int          total = 0;
    int          bad   = 0;
    logic [84:0] sb[$];
    logic [84:0] last_out = '0;
    bit          mon_on   = 1'b0;

    task automatic chk(input string name, input logic [84:0] act, input logic [84:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {inexact, res}; rounding from remainder versus half-ulp
    function automatic logic [84:0] model(input logic [63:0] a, input bit sg, input bit b32,
                                          input bit dbl, input bit ext, input logic [1:0] m);
        logic [63:0] x, mag, rem, half, one;
        logic [64:0] man;
        logic [83:0] r;
        bit          neg, up;
        int          msb, p, sh, e;
        one = 64'd1;
        x   = b32 ? (sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        neg = sg && x[63];
        mag = neg ? (64'd0 - x) : x;
        if (mag == 64'd0)
            return '0;
`ifdef CVT_INT_FP_EXT_EN
        p = ext ? 64 : (dbl ? 53 : 24);
`else
        p = (ext || dbl) ? 53 : 24;
`endif
        msb = 0;
        for (int i = 0; i < 64; i++)
            if (mag[i]) msb = i;
        rem  = '0;
        half = '0;
        if (msb + 1 > p) begin
            sh   = msb + 1 - p;
            man  = {1'b0, mag >> sh};
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
        end else begin
            man = {1'b0, mag} << (p - 1 - msb);
        end
        case (m)
            2'd0:    up = (rem > half) || (rem == half && rem != 0 && man[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = neg && (rem != 0);
            default: up = !neg && (rem != 0);
        endcase
        man = man + {64'd0, up};
        e   = msb;
        if (man == (65'd1 << p)) begin
            man = man >> 1;
            e   = msb + 1;
        end
        r = '0;
        if (p == 24) begin
            r[31] = neg; r[30:23] = 8'(e + 127); r[22:0] = man[22:0];
        end else if (p == 53) begin
            r[63] = neg; r[62:52] = 11'(e + 1023); r[51:0] = man[51:0];
        end else begin
            r[83] = neg; r[82:68] = 15'(e + 16383); r[63:0] = man[63:0];
        end
        return {rem != 64'd0, r};
    endfunction

    task automatic issue(input bit e, input bit ce, input bit r, input logic [63:0] a,
                         input bit sg, input bit b32, input bit sn, input bit db, input bit ex,
                         input logic [1:0] m, input bit use_exp, input logic [84:0] expv);
        en = e; clkEn = ce; rst = r; A = a;
        isSigned = sg; is32b = b32; isSNG = sn; isDBL = db; isEXT = ex; rm = m;
        if (e && ce && !r)
            sb.push_back(use_exp ? expv : model(a, sg, b32, db, ex, m));
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            last_out = '0;
        end
        en  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            issue(0, 1, 0, 64'd0, 0, 0, 0, 0, 0, 2'd0, 0, '0);
    endtask

    task automatic dir(input logic [63:0] a, input bit sg, input bit b32, input bit sn,
                       input bit db, input bit ex, input logic [1:0] m, input logic [84:0] expv);
        issue(1, 1, 0, a, sg, b32, sn, db, ex, m, 1, expv);
    endtask

    // Monitor: a presented result must match the queue head; consumed on clkEn
    always @(negedge clk) begin
        if (mon_on) begin
            if (res_en) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_res_en: got res_en=1 expected 0 (res=%h)", res);
                end else begin
                    chk("result", {inexact, res}, sb[0]);
                    if (clkEn) begin
                        last_out = sb[0];
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("hold", {inexact, res}, last_out);
            end
        end
    end

    initial begin
        logic [63:0] a;
        en = 0; clkEn = 1; rst = 1; A = '0; isSigned = 0; is32b = 0;
        isSNG = 0; isDBL = 0; isEXT = 0; rm = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_res", {inexact, res}, '0);
        chk("reset_res_en", {84'd0, res_en}, '0);
        rst    = 0;
        mon_on = 1'b1;

        dir(64'd1, 0, 0, 0, 1, 0, 2'd0, {1'b0, 84'h3FF0000000000000});
        dir(64'hFFFFFFFF, 1, 1, 1, 0, 0, 2'd0, {1'b0, 84'hBF800000});
        dir(64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 1, 0, 2'd0, {1'b1, 84'h43F0000000000000});
        dir(64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 1, 0, 2'd1, {1'b1, 84'h43EFFFFFFFFFFFFF});
        dir(64'h1000001, 0, 0, 1, 0, 0, 2'd0, {1'b1, 84'h4B800000});
        dir(64'h1000001, 0, 0, 1, 0, 0, 2'd3, {1'b1, 84'h4B800001});
        dir(64'hFFFFFFFFFEFFFFFF, 1, 0, 1, 0, 0, 2'd2, {1'b1, 84'hCB800001});
        dir(64'd0, 1, 0, 0, 1, 0, 2'd3, '0);
        dir(64'h8000000000000000, 1, 0, 0, 1, 0, 2'd0, {1'b0, 84'hC3E0000000000000});
`ifdef CVT_INT_FP_EXT_EN
        dir(64'd1, 0, 0, 0, 0, 1, 2'd0, {1'b0, 16'h3FFF, 4'h0, 64'h8000000000000000});
`else
        dir(64'd1, 0, 0, 0, 0, 1, 2'd0, {1'b0, 84'h3FF0000000000000});
`endif
        idle(5);

        for (int i = 0; i < 400; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                a = a >> $urandom_range(0, 63);
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 0, a,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 0, '0);
        end
        idle(6);

        // Stall: issue, freeze two edges with en pulsed, then advance
        issue(1, 1, 0, 64'd5, 0, 0, 0, 1, 0, 2'd0, 0, '0);
        issue(1, 0, 0, 64'd7, 0, 0, 0, 1, 0, 2'd0, 0, '0);
        chk("stall_e1_res_en", {84'd0, res_en}, '0);
        issue(1, 0, 0, 64'd9, 0, 0, 0, 1, 0, 2'd0, 0, '0);
        chk("stall_e2_res_en", {84'd0, res_en}, '0);
        issue(0, 1, 0, 64'd0, 0, 0, 0, 0, 0, 2'd0, 0, '0);
        chk("stall_e3_res_en", {84'd0, res_en}, '0);
        issue(0, 1, 0, 64'd0, 0, 0, 0, 0, 0, 2'd0, 0, '0);
        chk("stall_e4_res_en", {84'd0, res_en}, 85'd1);
        idle(4);

        // Reset mid-flight: third issue coincides with reset
        issue(1, 1, 0, 64'd11, 0, 0, 1, 0, 0, 2'd0, 0, '0);
        issue(1, 1, 0, 64'd12, 0, 0, 1, 0, 0, 2'd0, 0, '0);
        issue(1, 1, 1, 64'd13, 0, 0, 1, 0, 0, 2'd0, 0, '0);
        chk("rst_res", {inexact, res}, '0);
        chk("rst_res_en", {84'd0, res_en}, '0);
        idle(4);
        issue(1, 1, 0, 64'd100, 1, 0, 1, 0, 0, 2'd0, 1, {1'b0, 84'h42C80000});

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            idle(1);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        idle(2);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cvt_int_fp_mod.md
# cvt_int_fp_mod

- Three-stage pipelined integer-to-floating-point converter; the inverse of the FP-to-integer conversion unit on the FPU cluster 2 path.
- Accepts a 32- or 64-bit signed/unsigned integer and produces an IEEE single or double result, or an extended result, in the 84-bit FPU register format.
- Sits beside the cluster-2 FPU, fed from the integer side.
- Writes back through the same alternate-data path.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- clkEn  in  1  pipeline advance; 0 freezes every stage.
- en  in  1  start a conversion; sampled only when clkEn=1.
- A  in  64  integer operand; only [31:0] are used when is32b=1.
- isSigned  in  1  treat the operand as two's complement.
- is32b  in  1  operand is 32-bit; sign- or zero-extended per isSigned.
- isSNG, isDBL, isEXT  in  1 each  destination format; priority EXT > DBL > SNG; none set means SNG.
- rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward −inf), 3 RUP (toward +inf).
- res  out  84  result.
  - SNG: [31:0] IEEE single, other bits 0.
  - DBL: [63:0] IEEE double, other bits 0.
  - EXT: [83:68] = {sign, exp15}, [67:64] = 0, [63:0] = explicit 64-bit mantissa.
- res_en  out  1  res valid this cycle.
- inexact  out  1  result was rounded; qualified by res_en.

## Operation
- Stage S1, capture:
  - Latch the operand and controls.
  - Extend a 32-bit operand.
  - Compute sign = isSigned & MSB and mag = |A| as a 64-bit unsigned value; −2^63 gives mag 0x8000000000000000.
  - Set v1 = en.
- Stage S2, normalize:
  - 64-bit leading-zero count lz on mag.
  - norm = mag << lz.
  - Unbiased exponent e = 63 − lz.
  - zero flag = (mag == 0).
- Stage S3, round and pack:
  - Mantissa width p = 24 (SNG), 53 (DBL), 64 (EXT).
  - Keep norm[63:64−p]; guard = next bit; sticky = OR of the remaining bits.
  - Increment decision:
    - RNE: guard & (sticky | lsb).
    - RTZ: never.
    - RDN: sign & (guard | sticky).
    - RUP: ~sign & (guard | sticky).
  - A mantissa carry-out renormalizes to 1.0 and increments e.
  - Biased exponent = e + 127 / 1023 / 16383.
  - inexact = guard | sticky.
  - zero → +0 with all fields 0; the sign is never set for zero, and inexact = 0.
  - SNG and DBL drop the hidden bit; EXT keeps it explicitly.
- No overflow, underflow or denormal can occur: |int| < 2^64 fits every format.
- res_en = v3.
- res and inexact hold their last value while res_en = 0, and hold while frozen.

## Timing
- Latency: 3 advancing cycles.
  - en=1 with clkEn=1 at edge N → res_en=1 during the cycle after edge N+2, provided clkEn=1 on all three edges.
- Throughput: one conversion per advancing cycle, fully pipelined, no back-pressure output.
- clkEn=0:
  - v1, v2, v3 and all stage data hold; en is ignored and dropped.
  - res_en stays as is, so a valid result is presented for every frozen cycle.
  - The consumer must gate on its own clkEn.
- Reset:
  - Synchronous; rst=1 at an edge clears v1, v2, v3, res, inexact and res_en to 0.
  - Reset overrides clkEn.
  - In-flight conversions are discarded, never emitted.
- Reset and en asserted together: reset wins.
- Back-to-back en: each is emitted in order on consecutive advancing cycles.

## Configuration
- CVT_INT_FP_EXT_EN defined:
  - Extended format supported as above.
  - S3 rounding datapath is 64 bits wide.
- Not defined:
  - isEXT is ignored and treated as DBL.
  - The 64-bit EXT mantissa path and res[83:64] logic are removed; res[83:64] is always 0.

## Test plan
- Format and sign: A=1, unsigned, DBL, RNE → res = 0x3FF0000000000000 three cycles later, inexact=0. A=0xFFFFFFFF, is32b, signed, SNG → 0xBF800000.
- Rounding with carry:
  - A=0xFFFFFFFFFFFFFFFF unsigned, DBL, RNE → 0x43F0000000000000, inexact=1.
  - Same operand with RTZ → 0x43EFFFFFFFFFFFFF, inexact=1.
- Tie and directed modes:
  - A=0x1000001, SNG, RNE → 0x4B800000, inexact=1.
  - RUP → 0x4B800001.
  - Signed −0x1000001 with RDN → 0xCB800001.
- Edge values:
  - A=0 → res=0, inexact=0.
  - A=0x8000000000000000 signed, DBL → 0xC3E0000000000000, inexact=0.
  - With the macro defined: A=1, EXT → res[83:68]=0x3FFF, res[63:0]=0x8000000000000000.
- Stall: issue at edge 0, clkEn=0 on edges 1–2 → res_en first seen after edge 4. The value is held while clkEn=0. en pulsed during the stall produces no output.
- Reset mid-flight: three back-to-back issues, rst at edge 2 → res_en never asserts for them; res=0, inexact=0. The next issue completes normally.
